serial_add_seq_ctrl: RTL and testbench



---
 rtl/serial_add_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_serial_add_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_seq_ctrl
//
// Sequencer for an 8-bit bit-serial shift-add datapath.  It takes two
// operands through a Start/Done handshake, then drives the datapath through
// a fixed schedule:
//
//   IDLE -> CLEAR (1 cycle) -> LOAD (1 cycle) -> SHIFT (8 cycles) -> DONE -> IDLE
//
// CLEAR pulses the datapath's active-low clear so no carry survives from a
// previous operation.  LOAD parallel-loads operand A as the coefficient.
// SHIFT streams operand B LSB-first, one bit per cycle.  DONE waits for the
// final shift to settle and captures the sum from the datapath on its exit
// edge.  Every output is a register, so nothing passes combinationally from
// an input to an output.
//
// Ports
//   clk_i                rising-edge clock shared with the datapath
//   rst_i                asynchronous active-high reset
//   start_i              operation request, sampled only in IDLE
//   abort_i              cancels an operation in progress (ignored in IDLE)
//   operand_a_i[7:0]     coefficient operand, captured on accept
//   operand_b_i[7:0]     serial operand, captured on accept
//   parallel_out_i[7:0]  datapath result register
//   datapath_rst_n_o     active-low datapath clear (low in CLEAR and in reset)
//   para_load_o          datapath parallel-load strobe (LOAD only)
//   coeff_data_o[7:0]    datapath parallel-load data (A in LOAD, else 0)
//   serial_in_o          datapath serial bit (B[bit_count] in SHIFT, else 0)
//   enable_shift_add_o   datapath shift/add enable (SHIFT only)
//   busy_o               operation in progress
//   done_o               one-cycle completion pulse
//   result_o[7:0]        captured sum, held until the next completion
//   bit_count_o[2:0]     current shift index (debug)
// ---------------------------------------------------------------------------
module serial_add_seq_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] operand_a_i,
  input  logic [7:0] operand_b_i,
  input  logic [7:0] parallel_out_i,
  output logic       datapath_rst_n_o,
  output logic       para_load_o,
  output logic [7:0] coeff_data_o,
  output logic       serial_in_o,
  output logic       enable_shift_add_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] result_o,
  output logic [2:0] bit_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] LAST_BIT = 3'd7;

  // Selects one bit of the serial operand; kept as a function so the
  // indexing rule lives in one place.
  function automatic logic sel_bit(input logic [7:0] word, input logic [2:0] idx);
    return word[idx];
  endfunction

  // State and captured operands
  state_e     state_q,  state_d;
  logic [7:0] op_a_q,   op_a_d;
  logic [7:0] op_b_q,   op_b_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  // Registered outputs
  logic       dp_rst_n_q, dp_rst_n_d;
  logic       para_load_q, para_load_d;
  logic [7:0] coeff_q,    coeff_d;
  logic       serial_q,   serial_d;
  logic       en_q,       en_d;
  logic       busy_q,     busy_d;
  logic       done_q,     done_d;
  logic [7:0] result_q,   result_d;

  // Next-state and next-output logic.  Outputs are derived from the state
  // being entered so that each strobe is high exactly while its state is.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    bit_cnt_d = bit_cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Start wins over Abort here: Abort has no meaning while idle.
          op_a_d    = operand_a_i;
          op_b_d    = operand_b_i;
          bit_cnt_d = 3'd0;
          state_d   = ST_CLEAR;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bit_cnt_d = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // The last shift landed at the edge entering DONE, so the
        // datapath output is stable for the whole cycle.
        result_d = parallel_out_i;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        // Unreachable encodings fall back to a safe idle.
        bit_cnt_d = 3'd0;
        state_d   = ST_IDLE;
      end
    endcase

    // Abort cancels any non-idle state, including DONE, so an aborted
    // operation never reports completion or touches the result.
    if ((state_q != ST_IDLE) && abort_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      done_d    = 1'b0;
      result_d  = result_q;
    end else begin
      state_d   = state_d;
    end

    busy_d      = (state_d != ST_IDLE);
    dp_rst_n_d  = (state_d != ST_CLEAR);
    para_load_d = (state_d == ST_LOAD);
    en_d        = (state_d == ST_SHIFT);

    if (state_d == ST_LOAD) begin
      coeff_d = op_a_d;
    end else begin
      coeff_d = 8'h00;
    end

    if (state_d == ST_SHIFT) begin
      serial_d = sel_bit(op_b_d, bit_cnt_d);
    end else begin
      serial_d = 1'b0;
    end
  end

  // Sequencer state and output registers; reset holds the datapath cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      bit_cnt_q   <= 3'd0;
      dp_rst_n_q  <= 1'b0;
      para_load_q <= 1'b0;
      coeff_q     <= 8'h00;
      serial_q    <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      bit_cnt_q   <= bit_cnt_d;
      dp_rst_n_q  <= dp_rst_n_d;
      para_load_q <= para_load_d;
      coeff_q     <= coeff_d;
      serial_q    <= serial_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
    end
  end

  assign datapath_rst_n_o   = dp_rst_n_q;
  assign para_load_o        = para_load_q;
  assign coeff_data_o       = coeff_q;
  assign serial_in_o        = serial_q;
  assign enable_shift_add_o = en_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign result_o           = result_q;
  assign bit_count_o        = bit_cnt_q;

endmodule

// File: tb/tb_serial_add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for serial_add_seq_ctrl.  A small bit-serial adder stands in for
// the real datapath; expected sums come from plain 8-bit addition, and the
// per-cycle strobe pattern is checked against the edge-numbered schedule.
// ---------------------------------------------------------------------------
module tb_serial_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] parallel_out;
  logic       dp_rst_n;
  logic       para_load;
  logic [7:0] coeff;
  logic       serial_in;
  logic       en;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [2:0] bit_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] last_res;

  always #5 clk = ~clk;

  serial_add_seq_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .start_i            (start),
    .abort_i            (abort),
    .operand_a_i        (operand_a),
    .operand_b_i        (operand_b),
    .parallel_out_i     (parallel_out),
    .datapath_rst_n_o   (dp_rst_n),
    .para_load_o        (para_load),
    .coeff_data_o       (coeff),
    .serial_in_o        (serial_in),
    .enable_shift_add_o (en),
    .busy_o             (busy),
    .done_o             (done),
    .result_o           (result),
    .bit_count_o        (bit_count)
  );

  // Bit-serial shift-add datapath: loads A, then adds one B bit per enable,
  // shifting the sum bit in at the MSB; the carry persists until cleared.
  logic [7:0] dp_sr;
  logic       dp_c;
  always @(posedge clk) begin
    if (!dp_rst_n) begin
      dp_sr <= 8'h00;
      dp_c  <= 1'b0;
    end else if (para_load) begin
      dp_sr <= coeff;
    end else if (en) begin
      dp_sr <= {dp_sr[0] ^ serial_in ^ dp_c, dp_sr[7:1]};
      dp_c  <= (dp_sr[0] & serial_in) | (dp_sr[0] & dp_c) | (serial_in & dp_c);
    end
  end
  assign parallel_out = dp_sr;

  // Reference: 8-bit sum with the carry-out discarded.
  function automatic logic [7:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = (int'(a) + int'(b)) % 256;
    return s[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks cycles E1..E11 of an operation accepted at E0.
  task automatic check_op_cycles(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    logic shift;
    int   idx;
    for (int k = 1; k <= 11; k++) begin
      operand_a = 8'($urandom);
      operand_b = 8'($urandom);
      tick();
      shift = (k >= 2) && (k <= 9);
      idx   = shift ? (k - 2) : 0;
      chk("busy",      busy,      (k < 11));
      chk("done",      done,      (k == 11));
      chk("dp_rst_n",  dp_rst_n,  1);
      chk("para_load", para_load, (k == 1));
      chk("coeff",     coeff,     (k == 1) ? a : 8'h00);
      chk("enable",    en,        shift);
      chk("serial",    serial_in, shift ? b[idx] : 1'b0);
      if (shift) chk("bit_count", bit_count, idx);
      if (k == 11) chk("result", result, exp);
    end
    last_res = exp;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                        input logic with_abort);
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    abort     = with_abort;
    tick();                      // E0
    start = 1'b0;
    abort = 1'b0;
    chk("e0_busy",     busy,      1);
    chk("e0_dp_rst_n", dp_rst_n,  0);
    chk("e0_para",     para_load, 0);
    chk("e0_enable",   en,        0);
    chk("e0_done",     done,      0);
    check_op_cycles(a, b, exp);
    tick();                      // E12
    chk("e12_done", done, 0);
    chk("e12_result_hold", result, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     busy,      0);
    chk({tag, "_done"},     done,      0);
    chk({tag, "_result"},   result,    8'h00);
    chk({tag, "_bitcnt"},   bit_count, 3'd0);
    chk({tag, "_para"},     para_load, 0);
    chk({tag, "_coeff"},    coeff,     8'h00);
    chk({tag, "_enable"},   en,        0);
    chk({tag, "_serial"},   serial_in, 0);
    chk({tag, "_dp_rst_n"}, dp_rst_n,  0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    vecs[0] = '{8'h25, 8'h13, 8'h38};
    vecs[1] = '{8'hFF, 8'h01, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE};
    vecs[3] = '{8'h01, 8'h00, 8'h01};   // 0x02 here would mean a leaked carry
    vecs[4] = '{8'h80, 8'h80, 8'h00};
    vecs[5] = '{8'h7F, 8'h01, 8'h80};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    operand_a = 8'h00; operand_b = 8'h00;
    last_res = 8'h00;
    #2;
    chk_reset_vals("rst");
    tick();
    tick();
    rst = 1'b0;
    chk("post_rst_dp_rst_n_low", dp_rst_n, 0);
    tick();
    chk("post_rst_dp_rst_n_high", dp_rst_n, 1);
    chk("idle_busy", busy, 0);

    // Table vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    // Start and Abort together in IDLE: Start wins.
    run_op(8'h21, 8'h42, 8'h63, 1'b1);

    // Abort at E5: no Done, result unchanged, then a clean operation.
    operand_a = 8'h10; operand_b = 8'h20; start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    abort = 1'b1;
    tick();                      // E5
    abort = 1'b0;
    chk("abort_busy",     busy,      0);
    chk("abort_enable",   en,        0);
    chk("abort_serial",   serial_in, 0);
    chk("abort_para",     para_load, 0);
    chk("abort_dp_rst_n", dp_rst_n,  1);
    chk("abort_done",     done,      0);
    chk("abort_result",   result,    last_res);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    run_op(8'h03, 8'h04, 8'h07, 1'b0);

    // Start held high with changing operands: first op only, next at E12.
    operand_a = 8'h11; operand_b = 8'h22; start = 1'b1;
    tick();                      // E0
    check_op_cycles(8'h11, 8'h22, 8'h33);
    operand_a = 8'h55; operand_b = 8'h66;
    tick();                      // E12: second accept
    start = 1'b0;
    chk("hold_e12_done", done, 0);
    chk("hold_e12_busy", busy, 1);
    chk("hold_e12_dp_rst_n", dp_rst_n, 0);
    check_op_cycles(8'h55, 8'h66, 8'hBB);
    tick();

    // Reset at E6 of an operation.
    operand_a = 8'h40; operand_b = 8'h30; start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    @(posedge clk);              // E6
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst = 1'b0;
    chk("midrst_done", done, 0);
    tick();
    chk("midrst_dp_rst_n", dp_rst_n, 1);
    run_op(8'h0A, 8'h05, 8'h0F, 1'b0);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_sum(ra, rb), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
